alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station for the integer ALU; sits between the dispatcher and the ALU.
- Buffers decoded ALU-class instructions (OP, OP-IMM, AUIPC, JAL, branch) until both source operands are known.
- Snoops the ALU and LSB result buses to capture missing operands.
- Issues at most one ready instruction per cycle to the ALU through registered outputs.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- RS_IDX, 3, log2(RS_SIZE).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global enable; low freezes all state and outputs
- rollback_config  input  1  misprediction flush
- in_config  input  1  dispatch valid
- in_opcode  input  7  opcode
- in_precise  input  3  funct3
- in_more_precise  input  1  funct7[5]
- in_qj_valid  input  1  1 = operand a known in in_vj
- in_vj  input  32  operand a value
- in_qj  input  4  ROB tag producing operand a
- in_qk_valid  input  1  1 = operand b known in in_vk
- in_vk  input  32  operand b value
- in_qk  input  4  ROB tag producing operand b
- in_imm  input  32  immediate
- in_PC  input  32  instruction PC
- in_rob_entry  input  4  destination ROB tag
- alu_cdb_config  input  1  ALU result broadcast valid
- alu_cdb_rob_entry  input  4  ALU result tag
- alu_cdb_val  input  32  ALU result value
- lsb_cdb_config  input  1  LSB result broadcast valid
- lsb_cdb_rob_entry  input  4  LSB result tag
- lsb_cdb_val  input  32  LSB result value
- out_full  output  1  all entries busy (combinational from state)
- out_config  output  1  issue valid to ALU
- out_a, out_b, out_imm, out_PC  output  32 each  operands, immediate, PC to ALU
- out_opcode  output  7  opcode to ALU
- out_precise  output  3  funct3 to ALU
- out_more_precise  output  1  funct7[5] to ALU
- out_rob_entry  output  4  destination ROB tag to ALU

Behaviour:
- Entry state: busy, opcode, precise, more_precise, vj, qj, rj (ready), vk, qk, rk, imm, PC, rob_entry.
- Reset and rollback:
  - rst or rollback_config at an edge clears every busy bit.
  - All registered outputs go to 0: out_config 0, data and tags 0.
  - Overrides rdy, dispatch, wakeup and issue in the same cycle.
- Freeze: rdy low (with no rst or rollback) holds every register unchanged, including out_config.
- Dispatch:
  - When in_config && !out_full, the instruction is written into the lowest-index non-busy entry; busy is set.
  - Operand a: rj = in_qj_valid; vj = in_vj.
  - Same-edge bypass: if !in_qj_valid and a valid CDB tag equals in_qj, store that CDB value with rj = 1. Operand b identical with qk/vk/rk.
  - in_config while out_full is a dispatcher protocol violation; the instruction is dropped and state is unchanged.
- Wakeup:
  - Every edge, for each busy entry with !rj and a valid CDB whose tag equals qj, set vj to the CDB value and rj = 1. Same for k.
  - When both CDBs match the same tag, ALU CDB wins. (Tags are unique, so this is not expected.)
- Issue:
  - Each edge, select the lowest-index entry with busy && rj && rk, using pre-edge state.
  - Drive its fields to the out_* registers with out_config = 1, and clear its busy bit.
  - If none is ready, out_config = 0 and data outputs hold their previous values.
  - An entry woken or dispatched at edge e can issue at edge e+1 at the earliest. Dispatch-to-ALU latency with ready operands is 2 edges.
- Simultaneous events:
  - Dispatch and issue on the same edge are both allowed. The dispatch slot is chosen from pre-edge free entries, so it never collides with the issuing entry.
  - A freed entry becomes available for dispatch next cycle.
- out_full: high exactly when all RS_SIZE busy bits are set. It does not anticipate same-cycle issue.
- Ordering: the lowest-index-first policy is required for deterministic verification. Age ordering is not guaranteed.

Test Plan:
- Reset then dispatch ADD (opcode 0110011, precise 000) with vj=5, vk=7, both valid, rob 3 at edge 1 → edge 2: out_config=1, out_a=5, out_b=7, out_rob_entry=3; edge 3: out_config=0.
- Dispatch with qj=2 pending, vk=1 valid; at a later edge alu_cdb_config=1, tag 2, val 0x10 → issue one edge after the wakeup with out_a=0x10. No issue occurs before the wakeup.
- Dispatch with qk=4 pending in the same cycle that lsb_cdb broadcasts tag 4, val 0xABCD (bypass) → issues the next edge with out_b=0xABCD.
- Fill 8 entries all waiting on tag 9 → out_full=1 and a 9th in_config is ignored. Broadcast tag 9 → entries 0..7 issue on 8 consecutive edges in index order; out_full drops after the first issue.
- Load 3 entries, assert rollback_config for one edge → out_config=0 and out_full=0; no further issue even when their tags later broadcast.
- Hold rdy=0 for 3 cycles with a ready entry → outputs frozen and no issue. On rdy=1 the entry issues the next edge.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station for the integer ALU.
//
// Holds decoded ALU-class instructions (OP, OP-IMM, AUIPC, JAL, branch) until
// both source operands are known. It snoops the ALU and LSB result buses to
// capture missing operands, and issues at most one ready instruction per cycle
// through registered outputs. Issue picks the lowest ready index. Dispatch
// writes into the lowest free index.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state and outputs
//   rollback_config     misprediction flush (clears all entries)
//   in_*                dispatched instruction: opcode/funct fields, operand
//                       values/tags with valid flags, imm, PC, destination tag
//   alu_cdb_*, lsb_cdb_*  result broadcasts (valid, ROB tag, value)
//   out_full            all entries busy (combinational)
//   out_*               registered issue packet to the ALU
module alu_rs #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned RS_IDX  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_config,
    input  logic        in_config,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_precise,
    input  logic        in_more_precise,
    input  logic        in_qj_valid,
    input  logic [31:0] in_vj,
    input  logic [3:0]  in_qj,
    input  logic        in_qk_valid,
    input  logic [31:0] in_vk,
    input  logic [3:0]  in_qk,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_PC,
    input  logic [3:0]  in_rob_entry,
    input  logic        alu_cdb_config,
    input  logic [3:0]  alu_cdb_rob_entry,
    input  logic [31:0] alu_cdb_val,
    input  logic        lsb_cdb_config,
    input  logic [3:0]  lsb_cdb_rob_entry,
    input  logic [31:0] lsb_cdb_val,
    output logic        out_full,
    output logic        out_config,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_imm,
    output logic [31:0] out_PC,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_precise,
    output logic        out_more_precise,
    output logic [3:0]  out_rob_entry
);

    // Entry storage
    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_rj;
    logic [RS_SIZE-1:0] r_rk;
    logic [6:0]         r_opcode       [RS_SIZE];
    logic [2:0]         r_precise      [RS_SIZE];
    logic               r_more_precise [RS_SIZE];
    logic [31:0]        r_vj           [RS_SIZE];
    logic [31:0]        r_vk           [RS_SIZE];
    logic [3:0]         r_qj           [RS_SIZE];
    logic [3:0]         r_qk           [RS_SIZE];
    logic [31:0]        r_imm          [RS_SIZE];
    logic [31:0]        r_pc           [RS_SIZE];
    logic [3:0]         r_rob          [RS_SIZE];

    logic [RS_SIZE-1:0] w_ready;
    logic               w_issue_valid;
    logic [RS_IDX-1:0]  w_issue_idx;
    logic [RS_IDX-1:0]  w_free_idx;
    logic               w_disp;
    logic               w_alu_j, w_lsb_j, w_alu_k, w_lsb_k;
    logic               w_disp_rj, w_disp_rk;
    logic [31:0]        w_disp_vj, w_disp_vk;

    assign out_full = &r_busy;
    assign w_disp   = in_config && !out_full;
    assign w_ready  = r_busy & r_rj & r_rk;
    assign w_issue_valid = |w_ready;

    // Lowest-index search: scan downward so the smallest match is written last.
    always_comb begin
        w_issue_idx = '0;
        w_free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) w_issue_idx = RS_IDX'(i);
            if (!r_busy[i]) w_free_idx = RS_IDX'(i);
        end
    end

    // Same-edge bypass of a broadcast into the dispatched operands; ALU bus wins.
    always_comb begin
        w_alu_j   = alu_cdb_config && (alu_cdb_rob_entry == in_qj);
        w_lsb_j   = lsb_cdb_config && (lsb_cdb_rob_entry == in_qj);
        w_alu_k   = alu_cdb_config && (alu_cdb_rob_entry == in_qk);
        w_lsb_k   = lsb_cdb_config && (lsb_cdb_rob_entry == in_qk);
        w_disp_rj = in_qj_valid || w_alu_j || w_lsb_j;
        w_disp_rk = in_qk_valid || w_alu_k || w_lsb_k;
        w_disp_vj = in_qj_valid ? in_vj : (w_alu_j ? alu_cdb_val : lsb_cdb_val);
        w_disp_vk = in_qk_valid ? in_vk : (w_alu_k ? alu_cdb_val : lsb_cdb_val);
    end

    always_ff @(posedge clk) begin
        if (rst || rollback_config) begin
            r_busy           <= '0;
            out_config       <= 1'b0;
            out_a            <= '0;
            out_b            <= '0;
            out_imm          <= '0;
            out_PC           <= '0;
            out_opcode       <= '0;
            out_precise      <= '0;
            out_more_precise <= 1'b0;
            out_rob_entry    <= '0;
        end else if (rdy) begin
            // Wakeup of waiting operands in busy entries.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && !r_rj[i]) begin
                    if (alu_cdb_config && alu_cdb_rob_entry == r_qj[i]) begin
                        r_vj[i] <= alu_cdb_val;
                        r_rj[i] <= 1'b1;
                    end else if (lsb_cdb_config && lsb_cdb_rob_entry == r_qj[i]) begin
                        r_vj[i] <= lsb_cdb_val;
                        r_rj[i] <= 1'b1;
                    end
                end
                if (r_busy[i] && !r_rk[i]) begin
                    if (alu_cdb_config && alu_cdb_rob_entry == r_qk[i]) begin
                        r_vk[i] <= alu_cdb_val;
                        r_rk[i] <= 1'b1;
                    end else if (lsb_cdb_config && lsb_cdb_rob_entry == r_qk[i]) begin
                        r_vk[i] <= lsb_cdb_val;
                        r_rk[i] <= 1'b1;
                    end
                end
            end

            // Issue from pre-edge state; data outputs hold when nothing is ready.
            out_config <= w_issue_valid;
            if (w_issue_valid) begin
                r_busy[w_issue_idx] <= 1'b0;
                out_a               <= r_vj[w_issue_idx];
                out_b               <= r_vk[w_issue_idx];
                out_imm             <= r_imm[w_issue_idx];
                out_PC              <= r_pc[w_issue_idx];
                out_opcode          <= r_opcode[w_issue_idx];
                out_precise         <= r_precise[w_issue_idx];
                out_more_precise    <= r_more_precise[w_issue_idx];
                out_rob_entry       <= r_rob[w_issue_idx];
            end

            // Free slot is never the issuing slot, since issue needs busy.
            if (w_disp) begin
                r_busy[w_free_idx]         <= 1'b1;
                r_opcode[w_free_idx]       <= in_opcode;
                r_precise[w_free_idx]      <= in_precise;
                r_more_precise[w_free_idx] <= in_more_precise;
                r_rj[w_free_idx]           <= w_disp_rj;
                r_vj[w_free_idx]           <= w_disp_vj;
                r_qj[w_free_idx]           <= in_qj;
                r_rk[w_free_idx]           <= w_disp_rk;
                r_vk[w_free_idx]           <= w_disp_vk;
                r_qk[w_free_idx]           <= in_qk;
                r_imm[w_free_idx]          <= in_imm;
                r_pc[w_free_idx]           <= in_PC;
                r_rob[w_free_idx]          <= in_rob_entry;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for alu_rs. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback_config;
    logic        in_config;
    logic [6:0]  in_opcode;
    logic [2:0]  in_precise;
    logic        in_more_precise;
    logic        in_qj_valid, in_qk_valid;
    logic [31:0] in_vj, in_vk, in_imm, in_PC;
    logic [3:0]  in_qj, in_qk, in_rob_entry;
    logic        alu_cdb_config, lsb_cdb_config;
    logic [3:0]  alu_cdb_rob_entry, lsb_cdb_rob_entry;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic        out_full, out_config, out_more_precise;
    logic [31:0] out_a, out_b, out_imm, out_PC;
    logic [6:0]  out_opcode;
    logic [2:0]  out_precise;
    logic [3:0]  out_rob_entry;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_rs dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .rollback_config   (rollback_config),
        .in_config         (in_config),
        .in_opcode         (in_opcode),
        .in_precise        (in_precise),
        .in_more_precise   (in_more_precise),
        .in_qj_valid       (in_qj_valid),
        .in_vj             (in_vj),
        .in_qj             (in_qj),
        .in_qk_valid       (in_qk_valid),
        .in_vk             (in_vk),
        .in_qk             (in_qk),
        .in_imm            (in_imm),
        .in_PC             (in_PC),
        .in_rob_entry      (in_rob_entry),
        .alu_cdb_config    (alu_cdb_config),
        .alu_cdb_rob_entry (alu_cdb_rob_entry),
        .alu_cdb_val       (alu_cdb_val),
        .lsb_cdb_config    (lsb_cdb_config),
        .lsb_cdb_rob_entry (lsb_cdb_rob_entry),
        .lsb_cdb_val       (lsb_cdb_val),
        .out_full          (out_full),
        .out_config        (out_config),
        .out_a             (out_a),
        .out_b             (out_b),
        .out_imm           (out_imm),
        .out_PC            (out_PC),
        .out_opcode        (out_opcode),
        .out_precise       (out_precise),
        .out_more_precise  (out_more_precise),
        .out_rob_entry     (out_rob_entry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Dispatch one ADD for one edge, then drop in_config and both CDB valids.
    task automatic dispatch(input logic qjv, input logic [31:0] vj, input logic [3:0] qj,
                            input logic qkv, input logic [31:0] vk, input logic [3:0] qk,
                            input logic [3:0] rob);
        in_config    = 1'b1;
        in_opcode    = 7'b0110011;
        in_precise   = 3'b000;
        in_qj_valid  = qjv;
        in_vj        = vj;
        in_qj        = qj;
        in_qk_valid  = qkv;
        in_vk        = vk;
        in_qk        = qk;
        in_rob_entry = rob;
        in_imm       = 32'h1000 + 32'(rob);
        in_PC        = 32'h8000_0000 + 32'(rob) * 4;
        step();
        in_config      = 1'b0;
        alu_cdb_config = 1'b0;
        lsb_cdb_config = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback_config = 1'b0;
        in_config = 1'b0; in_opcode = '0; in_precise = '0; in_more_precise = 1'b0;
        in_qj_valid = 1'b0; in_qk_valid = 1'b0; in_vj = '0; in_vk = '0;
        in_qj = '0; in_qk = '0; in_imm = '0; in_PC = '0; in_rob_entry = '0;
        alu_cdb_config = 1'b0; alu_cdb_rob_entry = '0; alu_cdb_val = '0;
        lsb_cdb_config = 1'b0; lsb_cdb_rob_entry = '0; lsb_cdb_val = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("rst_config", 32'(out_config), 0);
        check("rst_full", 32'(out_full), 0);
        check("rst_a", out_a, 0);

        // Ready ADD: dispatched at edge 1, issued at edge 2.
        dispatch(1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        check("add_e1_config", 32'(out_config), 0);
        step();
        check("add_config", 32'(out_config), 1);
        check("add_a", out_a, 5);
        check("add_b", out_b, 7);
        check("add_rob", 32'(out_rob_entry), 3);
        check("add_opcode", 32'(out_opcode), 32'h33);
        check("add_imm", out_imm, 32'h1003);
        check("add_pc", out_PC, 32'h8000_000C);
        step();
        check("add_e3_config", 32'(out_config), 0);
        check("add_e3_hold_a", out_a, 5);

        // Operand a waits on tag 2, woken by the ALU bus.
        dispatch(1'b0, 32'hDEAD, 4'd2, 1'b1, 32'd1, 4'd0, 4'd5);
        step();
        check("wait_noissue1", 32'(out_config), 0);
        step();
        check("wait_noissue2", 32'(out_config), 0);
        alu_cdb_config = 1'b1; alu_cdb_rob_entry = 4'd2; alu_cdb_val = 32'h10;
        step();
        alu_cdb_config = 1'b0;
        check("wake_edge_config", 32'(out_config), 0);
        step();
        check("wake_config", 32'(out_config), 1);
        check("wake_a", out_a, 32'h10);
        check("wake_b", out_b, 1);
        check("wake_rob", 32'(out_rob_entry), 5);

        // Operand b captured by same-edge bypass from the LSB bus.
        lsb_cdb_config = 1'b1; lsb_cdb_rob_entry = 4'd4; lsb_cdb_val = 32'hABCD;
        dispatch(1'b1, 32'd3, 4'd0, 1'b0, 32'd0, 4'd4, 4'd6);
        check("byp_e1_config", 32'(out_config), 0);
        step();
        check("byp_config", 32'(out_config), 1);
        check("byp_a", out_a, 3);
        check("byp_b", out_b, 32'hABCD);
        check("byp_rob", 32'(out_rob_entry), 6);

        // Fill all entries waiting on tag 9.
        for (int i = 0; i < 8; i++) dispatch(1'b0, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0, 4'(i));
        check("fill_full", 32'(out_full), 1);
        // Ready instruction while full must be dropped.
        dispatch(1'b1, 32'h55, 4'd0, 1'b1, 32'h66, 4'd0, 4'd15);
        check("full_drop_config", 32'(out_config), 0);
        check("full_still", 32'(out_full), 1);
        alu_cdb_config = 1'b1; alu_cdb_rob_entry = 4'd9; alu_cdb_val = 32'h100;
        step();
        alu_cdb_config = 1'b0;
        check("fill_wake_config", 32'(out_config), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_config", 32'(out_config), 1);
            check("drain_rob", 32'(out_rob_entry), 32'(i));
            check("drain_b", out_b, 32'(i));
            check("drain_a", out_a, 32'h100);
            if (i == 0) check("drain_full", 32'(out_full), 0);
        end
        step();
        check("drain_done", 32'(out_config), 0);

        // Rollback discards waiting entries and zeroes the outputs.
        for (int i = 0; i < 3; i++) dispatch(1'b0, 32'd0, 4'd6, 1'b1, 32'd1, 4'd0, 4'(i + 8));
        rollback_config = 1'b1;
        step();
        rollback_config = 1'b0;
        check("rb_config", 32'(out_config), 0);
        check("rb_full", 32'(out_full), 0);
        check("rb_a", out_a, 0);
        check("rb_rob", 32'(out_rob_entry), 0);
        alu_cdb_config = 1'b1; alu_cdb_rob_entry = 4'd6; alu_cdb_val = 32'h77;
        step();
        alu_cdb_config = 1'b0;
        step();
        check("rb_noissue1", 32'(out_config), 0);
        step();
        check("rb_noissue2", 32'(out_config), 0);

        // Freeze: A issues, then rdy low holds that packet and blocks B.
        dispatch(1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 4'd7);
        dispatch(1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0, 4'd8);
        check("frz_a_config", 32'(out_config), 1);
        check("frz_a_rob", 32'(out_rob_entry), 7);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_config", 32'(out_config), 1);
            check("frz_rob", 32'(out_rob_entry), 7);
            check("frz_a", out_a, 32'h11);
        end
        rdy = 1'b1;
        step();
        check("thaw_config", 32'(out_config), 1);
        check("thaw_rob", 32'(out_rob_entry), 8);
        check("thaw_a", out_a, 32'h33);
        check("thaw_b", out_b, 32'h44);
        step();
        check("thaw_idle", 32'(out_config), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
